// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter that serialises whole-block reads and writes
// onto a single fixed-latency main memory and returns a one-cycle ack.
module mem_arbiter #(
    parameter int unsigned PA_WIDTH  = 32,
    parameter int unsigned BLK_WIDTH = 128,
    parameter int unsigned MEM_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [PA_WIDTH-1:0]  c0_addr,
    input  logic                 c0_rd_en,
    input  logic                 c0_wr_en,
    input  logic [BLK_WIDTH-1:0] c0_wr_blk,
    output logic [BLK_WIDTH-1:0] c0_rd_blk,
    output logic                 c0_ack,

    input  logic [PA_WIDTH-1:0]  c1_addr,
    input  logic                 c1_rd_en,
    input  logic                 c1_wr_en,
    input  logic [BLK_WIDTH-1:0] c1_wr_blk,
    output logic [BLK_WIDTH-1:0] c1_rd_blk,
    output logic                 c1_ack,

    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_blk,
    input  logic [BLK_WIDTH-1:0] mem_rd_blk,

    output logic                 busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   gnt_q, gnt_d;
    logic                   op_wr_q, op_wr_d;
    logic                   last_q, last_d;
    logic [PA_WIDTH-1:0]    addr_q, addr_d;
    logic [BLK_WIDTH-1:0]   wblk_q, wblk_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic                   mem_wr_en_q, mem_wr_en_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [BLK_WIDTH-1:0]   rblk0_q, rblk0_d;
    logic [BLK_WIDTH-1:0]   rblk1_q, rblk1_d;
    logic                   busy_q, busy_d;

    logic                   req0, req1, sel;

    assign req0 = c0_rd_en | c0_wr_en;
    assign req1 = c1_rd_en | c1_wr_en;

    assign mem_addr   = addr_q;
    assign mem_wr_blk = wblk_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign c0_ack     = ack0_q;
    assign c1_ack     = ack1_q;
    assign c0_rd_blk  = rblk0_q;
    assign c1_rd_blk  = rblk1_q;
    assign busy       = busy_q;

    // Next-state logic: arbitration in IDLE, countdown in ACCESS, ack in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        op_wr_d     = op_wr_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wblk_d      = wblk_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rblk0_d     = rblk0_q;
        rblk1_d     = rblk1_q;
        sel         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the client that did not win last time goes first.
                    sel         = (req0 && req1) ? ~last_q : req1;
                    gnt_d       = sel;
                    addr_d      = sel ? c1_addr   : c0_addr;
                    wblk_d      = sel ? c1_wr_blk : c0_wr_blk;
                    // A write wins over a simultaneous read on the same client.
                    op_wr_d     = sel ? c1_wr_en  : c0_wr_en;
                    cnt_d       = LAT_LOAD;
                    mem_rd_en_d = ~op_wr_d;
                    mem_wr_en_d = op_wr_d;
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    if (!op_wr_q) begin
                        if (gnt_q) rblk1_d = mem_rd_blk;
                        else       rblk0_d = mem_rd_blk;
                    end
                    ack0_d = ~gnt_q;
                    ack1_d = gnt_q;
                end else begin
                    mem_rd_en_d = ~op_wr_q;
                    mem_wr_en_d = op_wr_q;
                end
            end

            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            op_wr_q     <= 1'b0;
            last_q      <= 1'b1;
            addr_q      <= '0;
            wblk_q      <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rblk0_q     <= '0;
            rblk1_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            op_wr_q     <= op_wr_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wblk_q      <= wblk_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rblk0_q     <= rblk0_d;
            rblk1_q     <= rblk1_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;

    localparam int unsigned PA_W  = 32;
    localparam int unsigned BLK_W = 128;
    localparam int unsigned LAT   = 4;

    localparam logic [BLK_W-1:0] BLK_ZERO = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [BLK_W-1:0] BLK_A    = 128'haaaa_1111_aaaa_2222_aaaa_3333_aaaa_4444;
    localparam logic [BLK_W-1:0] BLK_B    = 128'hbbbb_5555_bbbb_6666_bbbb_7777_bbbb_8888;
    localparam logic [BLK_W-1:0] BLK_FA   = {16{8'hfa}};
    localparam logic [BLK_W-1:0] BLK_C    = 128'hc0de_c0de_1234_5678_9abc_def0_c0de_c0de;

    logic             clk = 1'b0;
    logic             rst;
    logic [PA_W-1:0]  c0_addr, c1_addr, mem_addr;
    logic             c0_rd_en, c0_wr_en, c1_rd_en, c1_wr_en;
    logic [BLK_W-1:0] c0_wr_blk, c1_wr_blk, c0_rd_blk, c1_rd_blk;
    logic             c0_ack, c1_ack;
    logic             mem_rd_en, mem_wr_en, busy;
    logic [BLK_W-1:0] mem_wr_blk, mem_rd_blk;

    int n_checks = 0;
    int n_pass   = 0;
    int both_ack = 0;
    int both_en  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.PA_WIDTH(PA_W), .BLK_WIDTH(BLK_W), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .c0_addr(c0_addr), .c0_rd_en(c0_rd_en), .c0_wr_en(c0_wr_en),
        .c0_wr_blk(c0_wr_blk), .c0_rd_blk(c0_rd_blk), .c0_ack(c0_ack),
        .c1_addr(c1_addr), .c1_rd_en(c1_rd_en), .c1_wr_en(c1_wr_en),
        .c1_wr_blk(c1_wr_blk), .c1_rd_blk(c1_rd_blk), .c1_ack(c1_ack),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk), .busy(busy)
    );

    // Behavioural memory: sparse storage, one-cycle registered read.
    logic [BLK_W-1:0] mem_q [logic [PA_W-1:0]];
    logic             pre_we = 1'b0;
    logic [PA_W-1:0]  pre_addr = '0;
    logic [BLK_W-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem_q[pre_addr] = pre_data;
        if (mem_wr_en) mem_q[mem_addr] = mem_wr_blk;
        mem_rd_blk <= mem_q.exists(mem_addr) ? mem_q[mem_addr] : '0;
    end

    // Protocol invariants watched every cycle.
    always @(negedge clk) begin
        if (c0_ack && c1_ack) both_ack++;
        if (mem_rd_en && mem_wr_en) both_en++;
    end

    task automatic check_eq(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic preload(input logic [PA_W-1:0] a, input logic [BLK_W-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic set_req(input int c, input logic rd, input logic wr,
                           input logic [PA_W-1:0] a, input logic [BLK_W-1:0] b);
        if (c == 0) begin
            c0_rd_en = rd; c0_wr_en = wr; c0_addr = a; c0_wr_blk = b;
        end else begin
            c1_rd_en = rd; c1_wr_en = wr; c1_addr = a; c1_wr_blk = b;
        end
    endtask

    // One transaction from an idle arbiter; counts enable cycles until the ack.
    task automatic run_txn(input string tag, input int c, input logic rd, input logic wr,
                           input logic [PA_W-1:0] a, input logic [BLK_W-1:0] b,
                           input int exp_rd, input int exp_wr);
        int   nrd = 0, nwr = 0, nbad = 0, nother = 0;
        logic done = 1'b0;
        logic own, other;
        set_req(c, rd, wr, a, b);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_rd_en) nrd++;
            if (mem_wr_en) nwr++;
            if ((mem_rd_en || mem_wr_en) && mem_addr != a) nbad++;
            own   = (c == 0) ? c0_ack : c1_ack;
            other = (c == 0) ? c1_ack : c0_ack;
            if (other) nother++;
            if (own) begin
                done = 1'b1;
                set_req(c, 1'b0, 1'b0, a, b);
            end
        end
        if (!done) set_req(c, 1'b0, 1'b0, a, b);
        check_eq({tag, "_ack_seen"}, BLK_W'(done), BLK_W'(1));
        check_eq({tag, "_rd_en_cycles"}, BLK_W'(nrd), BLK_W'(exp_rd));
        check_eq({tag, "_wr_en_cycles"}, BLK_W'(nwr), BLK_W'(exp_wr));
        check_eq({tag, "_addr_stable"}, BLK_W'(nbad), BLK_W'(0));
        check_eq({tag, "_other_ack"}, BLK_W'(nother), BLK_W'(0));
        @(negedge clk);
        own = (c == 0) ? c0_ack : c1_ack;
        check_eq({tag, "_ack_single"}, BLK_W'(own), BLK_W'(0));
    endtask

    initial begin
        int ack_id [4];
        int ack_cyc[4];
        int n_ack;
        int n_abort_ack;

        // Reset with both clients already requesting.
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h0000_2000, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_4000, '0);
        preload(32'h0000_0000, BLK_ZERO);
        preload(32'h0000_2000, BLK_A);
        preload(32'h0000_4000, BLK_B);
        check_eq("rst_c0_ack", BLK_W'(c0_ack), BLK_W'(0));
        check_eq("rst_c1_ack", BLK_W'(c1_ack), BLK_W'(0));
        check_eq("rst_mem_rd_en", BLK_W'(mem_rd_en), BLK_W'(0));
        check_eq("rst_mem_wr_en", BLK_W'(mem_wr_en), BLK_W'(0));
        check_eq("rst_busy", BLK_W'(busy), BLK_W'(0));
        check_eq("rst_mem_addr", BLK_W'(mem_addr), BLK_W'(0));
        check_eq("rst_c0_rd_blk", c0_rd_blk, '0);
        check_eq("rst_c1_rd_blk", c1_rd_blk, '0);

        // Release: client 0 must win the first tie.
        rst = 1'b0;
        @(negedge clk);
        check_eq("first_grant_addr", BLK_W'(mem_addr), BLK_W'(32'h0000_2000));
        check_eq("first_grant_rd_en", BLK_W'(mem_rd_en), BLK_W'(1));
        check_eq("first_grant_busy", BLK_W'(busy), BLK_W'(1));

        // Contention: both held, expect alternating acks spaced LAT+2 apart.
        n_ack = 0;
        for (int cyc = 0; cyc < 100 && n_ack < 4; cyc++) begin
            @(negedge clk);
            if (c0_ack || c1_ack) begin
                ack_id[n_ack]  = c1_ack ? 1 : 0;
                ack_cyc[n_ack] = cyc;
                if (c0_ack) check_eq("cont_c0_rd_blk", c0_rd_blk, BLK_A);
                if (c1_ack) check_eq("cont_c1_rd_blk", c1_rd_blk, BLK_B);
                n_ack++;
                if (n_ack == 4) begin
                    set_req(0, 1'b0, 1'b0, '0, '0);
                    set_req(1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check_eq("cont_ack_count", BLK_W'(n_ack), BLK_W'(4));
        if (n_ack == 4) begin
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("cont_order_%0d", i), BLK_W'(ack_id[i]), BLK_W'(i % 2));
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("cont_gap_%0d", i), BLK_W'(ack_cyc[i+1] - ack_cyc[i]), BLK_W'(LAT + 2));
        end
        repeat (2) @(negedge clk);
        check_eq("cont_idle_busy", BLK_W'(busy), BLK_W'(0));

        // Single read on client 0.
        run_txn("rd0", 0, 1'b1, 1'b0, 32'h0000_0000, '0, LAT, 0);
        check_eq("rd0_blk", c0_rd_blk, BLK_ZERO);
        check_eq("rd0_c1_blk_kept", c1_rd_blk, BLK_B);

        // Single write on client 1 then read it back.
        run_txn("wr1", 1, 1'b0, 1'b1, 32'h0000_20d5, BLK_FA, 0, LAT);
        check_eq("wr1_rd_blk_kept", c1_rd_blk, BLK_B);
        run_txn("rb1", 1, 1'b1, 1'b0, 32'h0000_20d5, '0, LAT, 0);
        check_eq("rb1_blk", c1_rd_blk, BLK_FA);
        check_eq("rb1_c0_blk_kept", c0_rd_blk, BLK_ZERO);

        // Reset during the second ACCESS cycle aborts without an ack.
        set_req(0, 1'b1, 1'b0, 32'h0000_2000, '0);
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_pre_rd_en", BLK_W'(mem_rd_en), BLK_W'(1));
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("abort_rd_en", BLK_W'(mem_rd_en), BLK_W'(0));
        check_eq("abort_busy", BLK_W'(busy), BLK_W'(0));
        check_eq("abort_ack", BLK_W'(c0_ack), BLK_W'(0));
        rst = 1'b0;
        n_abort_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (c0_ack || c1_ack || busy) n_abort_ack++;
        end
        check_eq("abort_quiet", BLK_W'(n_abort_ack), BLK_W'(0));

        // Illegal rd+wr: performs the write only, read block untouched.
        run_txn("pre_ill", 0, 1'b1, 1'b0, 32'h0000_2000, '0, LAT, 0);
        check_eq("pre_ill_blk", c0_rd_blk, BLK_A);
        run_txn("ill", 0, 1'b1, 1'b1, 32'h0000_6000, BLK_C, 0, LAT);
        check_eq("ill_blk_kept", c0_rd_blk, BLK_A);
        run_txn("ill_rb", 1, 1'b1, 1'b0, 32'h0000_6000, '0, LAT, 0);
        check_eq("ill_rb_blk", c1_rd_blk, BLK_C);

        check_eq("never_both_acks", BLK_W'(both_ack), BLK_W'(0));
        check_eq("never_both_en", BLK_W'(both_en), BLK_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
